// File: rtl/cpu_run_dump_ctrl.sv
// Run-control and state-dump unit: runs the CPU for a bounded cycle budget or until the PC sticks, then stalls it and streams registers and low data memory out.
// Latency: stall asserts on the edge that detects timeout/halt; first beat one edge later; one bubble cycle between the register and memory sections.
// Backpressure: a beat is held stable with its read index frozen while dump_valid_o && !dump_ready_i; no beat is lost or repeated.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), synchronous active-low reset
//   pc_i                       CPU program counter, watched for halt (PC unchanged)
//   cpu_stall_o                1 outside RUN: CPU holds PC and suppresses writes
//   reg_raddr_o / reg_rdata_i  asynchronous register-file debug read port
//   mem_raddr_o / mem_rdata_i  asynchronous data-memory debug read port (byte address)
//   dump_valid_o/dump_ready_i  beat handshake; dump_kind_o 0=reg 1=mem, dump_index_o, dump_data_o
//   done_o                     dump finished (sticky until reset)
//   halt_cause_o               {pc_halt, timeout}, frozen after RUN
//   cycle_cnt_o                unstalled cycles executed, frozen after RUN
module cpu_run_dump_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int END_COUNT   = 600,
  parameter int HALT_STABLE = 4,
  parameter int REG_CNT     = 32,
  parameter int MEM_WORDS   = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              cpu_stall_o,
  output logic [4:0]        reg_raddr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic              dump_kind_o,
  output logic [7:0]        dump_index_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o,
  output logic [1:0]        halt_cause_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  typedef enum logic [1:0] {RUN, DUMP_REG, DUMP_MEM, DONE} state_t;

  // Stable counter must be able to hold HALT_STABLE itself (saturation value).
  localparam int SC_W = $clog2(HALT_STABLE + 2);

  localparam logic [CNT_W-1:0] END_M1 = CNT_W'(END_COUNT - 1);
  localparam logic [SC_W-1:0]  HS_MAX = SC_W'(HALT_STABLE);
  localparam logic [SC_W-1:0]  HS_M1  = SC_W'(HALT_STABLE - 1);
  // idx must reach MEM_WORDS (up to 256) to mark the end of a section.
  localparam logic [8:0]       REG_N  = 9'(REG_CNT);
  localparam logic [8:0]       MEM_N  = 9'(MEM_WORDS);

  // Empty sections are skipped entirely so no bubble or beat is produced for them.
  localparam state_t AFTER_REG  = (MEM_WORDS != 0) ? DUMP_MEM : DONE;
  localparam state_t FIRST_DUMP = (REG_CNT != 0) ? DUMP_REG : AFTER_REG;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [ADDR_W-1:0]   prev_pc;
  logic                prev_vld;
  logic [SC_W-1:0]     stable_cnt;
  logic [8:0]          idx;
  logic [1:0]          halt_cause;
  logic                dump_valid;
  logic                dump_kind;
  logic [7:0]          dump_index;
  logic [DATA_W-1:0]   dump_data;

  logic                pc_same;
  logic                timeout;
  logic                halt;
  logic                load;
  logic                sect_end;
  logic [DATA_W-1:0]   rd_data;

  always_comb begin
    state_nxt   = state;
    // prev_vld keeps the first edge after reset from comparing against a stale PC.
    pc_same     = prev_vld && (pc_i == prev_pc);
    timeout     = (cycle_cnt == END_M1);
    halt        = (HALT_STABLE != 0) && pc_same && (stable_cnt == HS_M1);
    load        = !dump_valid || dump_ready_i;
    sect_end    = 1'b0;
    rd_data     = '0;
    reg_raddr_o = '0;
    mem_raddr_o = '0;
    case (state)
      RUN: begin
        if (timeout || halt) state_nxt = FIRST_DUMP;
      end
      DUMP_REG: begin
        reg_raddr_o = idx[4:0];
        rd_data     = reg_rdata_i;
        sect_end    = (idx == REG_N);
        if (load && sect_end) state_nxt = AFTER_REG;
      end
      DUMP_MEM: begin
        mem_raddr_o = ADDR_W'({idx, 2'b00});
        rd_data     = mem_rdata_i;
        sect_end    = (idx == MEM_N);
        if (load && sect_end) state_nxt = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt  <= '0;
      prev_pc    <= '0;
      prev_vld   <= 1'b0;
      stable_cnt <= '0;
      idx        <= '0;
      halt_cause <= 2'b00;
      dump_valid <= 1'b0;
      dump_kind  <= 1'b0;
      dump_index <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          prev_pc   <= pc_i;
          prev_vld  <= 1'b1;
          if (!pc_same)                 stable_cnt <= '0;
          else if (stable_cnt != HS_MAX) stable_cnt <= stable_cnt + 1'b1;
          if (timeout || halt) begin
            halt_cause <= {halt, timeout};
            idx        <= '0;
          end
        end
        DUMP_REG, DUMP_MEM: begin
          if (load) begin
            if (sect_end) begin
              // Last beat of the section drains here; this is the bubble cycle.
              dump_valid <= 1'b0;
              idx        <= '0;
            end else begin
              dump_data  <= rd_data;
              dump_kind  <= (state == DUMP_MEM);
              dump_index <= idx[7:0];
              dump_valid <= 1'b1;
              idx        <= idx + 1'b1;
            end
          end
        end
        default: dump_valid <= 1'b0;
      endcase
    end
  end

  assign cpu_stall_o  = (state != RUN);
  assign done_o       = (state == DONE);
  assign dump_valid_o = dump_valid;
  assign dump_kind_o  = dump_kind;
  assign dump_index_o = dump_index;
  assign dump_data_o  = dump_data;
  assign halt_cause_o = halt_cause;
  assign cycle_cnt_o  = cycle_cnt;

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
`timescale 1ns/1ps
module tb_cpu_run_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        kind;
    logic [7:0]  index;
    logic [31:0] data;
  } beat_t;

  // Instance A: timeout run, 4 registers + 3 memory words
  logic        rst_a, stall_a, valid_a, ready_a, kind_a, done_a;
  logic [31:0] pc_a, rdata_a, maddr_a, mdata_a, data_a;
  logic [4:0]  raddr_a;
  logic [7:0]  index_a;
  logic [1:0]  cause_a;
  logic [15:0] cyc_a;

  // Instance B: PC-halt run, empty dump
  logic        rst_b, stall_b, valid_b, kind_b, done_b;
  logic [31:0] pc_b, rdata_b, maddr_b, mdata_b, data_b;
  logic [4:0]  raddr_b;
  logic [7:0]  index_b;
  logic [1:0]  cause_b;
  logic [15:0] cyc_b;

  // Instance C: timeout and halt on the same edge, empty dump
  logic        rst_c, stall_c, valid_c, kind_c, done_c;
  logic [31:0] pc_c, rdata_c, maddr_c, mdata_c, data_c;
  logic [4:0]  raddr_c;
  logic [7:0]  index_c;
  logic [1:0]  cause_c;
  logic [15:0] cyc_c;

  // Register file returns 10*addr, memory returns byte address + 1
  assign rdata_a = {27'd0, raddr_a} * 32'd10;
  assign mdata_a = maddr_a + 32'd1;
  assign rdata_b = {27'd0, raddr_b} * 32'd10;
  assign mdata_b = maddr_b + 32'd1;
  assign rdata_c = {27'd0, raddr_c} * 32'd10;
  assign mdata_c = maddr_c + 32'd1;

  cpu_run_dump_ctrl #(.END_COUNT(20), .HALT_STABLE(0), .REG_CNT(4), .MEM_WORDS(3)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .pc_i(pc_a), .cpu_stall_o(stall_a),
    .reg_raddr_o(raddr_a), .reg_rdata_i(rdata_a), .mem_raddr_o(maddr_a), .mem_rdata_i(mdata_a),
    .dump_valid_o(valid_a), .dump_ready_i(ready_a), .dump_kind_o(kind_a), .dump_index_o(index_a),
    .dump_data_o(data_a), .done_o(done_a), .halt_cause_o(cause_a), .cycle_cnt_o(cyc_a));

  cpu_run_dump_ctrl #(.END_COUNT(600), .HALT_STABLE(4), .REG_CNT(0), .MEM_WORDS(0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .pc_i(pc_b), .cpu_stall_o(stall_b),
    .reg_raddr_o(raddr_b), .reg_rdata_i(rdata_b), .mem_raddr_o(maddr_b), .mem_rdata_i(mdata_b),
    .dump_valid_o(valid_b), .dump_ready_i(1'b1), .dump_kind_o(kind_b), .dump_index_o(index_b),
    .dump_data_o(data_b), .done_o(done_b), .halt_cause_o(cause_b), .cycle_cnt_o(cyc_b));

  cpu_run_dump_ctrl #(.END_COUNT(10), .HALT_STABLE(4), .REG_CNT(0), .MEM_WORDS(0)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .pc_i(pc_c), .cpu_stall_o(stall_c),
    .reg_raddr_o(raddr_c), .reg_rdata_i(rdata_c), .mem_raddr_o(maddr_c), .mem_rdata_i(mdata_c),
    .dump_valid_o(valid_c), .dump_ready_i(1'b1), .dump_kind_o(kind_c), .dump_index_o(index_c),
    .dump_data_o(data_c), .done_o(done_c), .halt_cause_o(cause_c), .cycle_cnt_o(cyc_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard
  beat_t       exp_q[$];
  logic        mon_en = 1'b0;
  int          nbeat  = 0;
  int unsigned t_beat [16];
  int          empty_beats = 0;

  // Sampled 3 ns before the rising edge; inputs change on the falling edge.
  always begin
    @(negedge clk);
    #3;
    if (valid_b || valid_c) empty_beats++;
    if (mon_en && valid_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat: got kind=%0d index=%0d data=0x%0h expected no beat",
                 kind_a, index_a, data_a);
      end else begin
        chk("beat_kind",  {63'd0, kind_a},  {63'd0, exp_q[0].kind});
        chk("beat_index", {56'd0, index_a}, {56'd0, exp_q[0].index});
        chk("beat_data",  {32'd0, data_a},  {32'd0, exp_q[0].data});
        if (ready_a) begin
          void'(exp_q.pop_front());
          if (nbeat < 16) t_beat[nbeat] = cyc;
          nbeat++;
        end
      end
    end
  end

  beat_t tbl [7];

  task automatic load_expected();
    for (int i = 0; i < 7; i++) exp_q.push_back(tbl[i]);
    nbeat = 0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_stall"}, {63'd0, stall_a}, 64'd0);
    chk({tag, "_valid"}, {63'd0, valid_a}, 64'd0);
    chk({tag, "_done"},  {63'd0, done_a},  64'd0);
    chk({tag, "_cycle"}, {48'd0, cyc_a},   64'd0);
    chk({tag, "_cause"}, {62'd0, cause_a}, 64'd0);
    chk({tag, "_kind"},  {63'd0, kind_a},  64'd0);
    chk({tag, "_index"}, {56'd0, index_a}, 64'd0);
    chk({tag, "_data"},  {32'd0, data_a},  64'd0);
  endtask

  int n;
  int k;

  initial begin
    tbl[0] = '{1'b0, 8'd0, 32'd0};
    tbl[1] = '{1'b0, 8'd1, 32'd10};
    tbl[2] = '{1'b0, 8'd2, 32'd20};
    tbl[3] = '{1'b0, 8'd3, 32'd30};
    tbl[4] = '{1'b1, 8'd0, 32'd1};
    tbl[5] = '{1'b1, 8'd1, 32'd5};
    tbl[6] = '{1'b1, 8'd2, 32'd9};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    pc_a = '0; pc_b = '0; pc_c = '0;
    ready_a = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");

    // A1: timeout after 20 edges, dump with ready tied high
    load_expected();
    mon_en = 1'b1;
    rst_a  = 1'b1;
    n = 0;
    while (!stall_a && n < 100) begin
      @(negedge clk);
      n++;
      pc_a = pc_a + 32'd4;
    end
    chk("timeout_edges", 64'(n), 64'd20);
    chk("timeout_cycle", {48'd0, cyc_a}, 64'd20);
    chk("timeout_cause", {62'd0, cause_a}, 64'd1);
    k = 0;
    while (!done_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("a1_done", {63'd0, done_a}, 64'd1);
    chk("a1_beats", 64'(nbeat), 64'd7);
    chk("a1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("a1_back_to_back", 64'(t_beat[1] - t_beat[0]), 64'd1);
    chk("a1_bubble", 64'(t_beat[4] - t_beat[3]), 64'd2);
    chk("a1_valid_in_done", {63'd0, valid_a}, 64'd0);
    chk("a1_stall_in_done", {63'd0, stall_a}, 64'd1);
    chk("a1_cycle_frozen", {48'd0, cyc_a}, 64'd20);

    // A2: same run, ready toggling 1-0-0-1
    mon_en = 1'b0;
    rst_a  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk_reset_a("reset_from_done");
    load_expected();
    mon_en = 1'b1;
    rst_a  = 1'b1;
    pc_a   = '0;
    k = 0;
    while (!done_a && k < 400) begin
      @(negedge clk);
      pc_a    = pc_a + 32'd4;
      ready_a = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
    end
    ready_a = 1'b1;
    chk("a2_done", {63'd0, done_a}, 64'd1);
    chk("a2_beats", 64'(nbeat), 64'd7);
    chk("a2_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("a2_cause", {62'd0, cause_a}, 64'd1);
    chk("a2_cycle", {48'd0, cyc_a}, 64'd20);

    // A3: reset in the middle of the memory section
    mon_en = 1'b0;
    rst_a  = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    pc_a  = '0;
    k = 0;
    while (!(valid_a && kind_a) && k < 200) begin
      @(negedge clk);
      pc_a = pc_a + 32'd4;
      k++;
    end
    chk("a3_reached_mem", {63'd0, (valid_a && kind_a)}, 64'd1);
    rst_a = 1'b0;
    @(negedge clk);
    chk_reset_a("mid_dump_reset");

    // B: PC 0x0..0x28 then held at 0x2c; halt on the 4th equal edge (edge 16)
    rst_b = 1'b1;
    pc_b  = '0;
    n = 0;
    while (!stall_b && n < 100) begin
      @(negedge clk);
      n++;
      pc_b = (n <= 10) ? 32'(4 * n) : 32'h2c;
    end
    chk("halt_edges", 64'(n), 64'd16);
    chk("halt_cycle", {48'd0, cyc_b}, 64'd16);
    chk("halt_cause", {62'd0, cause_b}, 64'd2);
    chk("empty_dump_done", {63'd0, done_b}, 64'd1);
    repeat (3) @(negedge clk);
    chk("empty_dump_done_held", {63'd0, done_b}, 64'd1);

    // C: PC held from edge 6, END_COUNT=10: both causes on edge 10
    rst_c = 1'b1;
    pc_c  = '0;
    n = 0;
    while (!stall_c && n < 100) begin
      @(negedge clk);
      n++;
      pc_c = (n < 5) ? 32'(4 * n) : 32'd20;
    end
    chk("both_edges", 64'(n), 64'd10);
    chk("both_cause", {62'd0, cause_c}, 64'd3);
    chk("both_cycle", {48'd0, cyc_c}, 64'd10);
    chk("both_done", {63'd0, done_c}, 64'd1);
    repeat (2) @(negedge clk);
    chk("empty_dump_no_beats", 64'(empty_beats), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_dump_ctrl.md
Name: cpu_run_dump_ctrl

Overview:
- Synthesizable run-control and state-dump unit for the single-cycle CPU.
- Lets the CPU run for a parametrised cycle budget, or until a halt is detected (PC stuck).
- Then stalls the CPU and streams a snapshot of the register file and the low data-memory words out over a valid/ready port.
- Sits beside the CPU top, using the asynchronous read ports of the register file and data memory. It replaces fixed end-of-run bench prints with a parametrised hardware dump.

Parameters:
- DATA_W, 32, register/memory data width
- ADDR_W, 32, PC and byte-address width
- CNT_W, 16, cycle counter width
- END_COUNT, 600, maximum unstalled run cycles (1..2^CNT_W-1)
- HALT_STABLE, 4, consecutive cycles of unchanged PC that mean halt; 0 disables halt detection
- REG_CNT, 32, registers dumped, indices 0..REG_CNT-1 (0..32)
- MEM_WORDS, 12, data-memory words dumped, byte addresses 0,4,..,4*(MEM_WORDS-1) (0..256)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-low reset
- pc_i  in  ADDR_W  current CPU program counter
- cpu_stall_o  out  1  1 = CPU must hold PC and suppress all writes
- reg_raddr_o  out  5  register-file debug read address
- reg_rdata_i  in  DATA_W  register-file read data (combinational)
- mem_raddr_o  out  ADDR_W  data-memory debug byte address
- mem_rdata_i  in  DATA_W  data-memory read data (combinational)
- dump_valid_o  out  1  dump beat valid
- dump_ready_i  in  1  consumer accepts beat
- dump_kind_o  out  1  0 = register beat, 1 = memory beat
- dump_index_o  out  8  register number or memory word index
- dump_data_o  out  DATA_W  beat payload
- done_o  out  1  dump complete
- halt_cause_o  out  2  00 none, 01 timeout, 10 PC halt, 11 both on the same edge
- cycle_cnt_o  out  CNT_W  unstalled cycles executed

Behaviour:
- Reset (rst_i == 0 at an edge) has priority over everything and applies even mid-dump.
  - State = RUN; cycle_cnt, stable_cnt, idx, halt_cause = 0.
  - dump_valid_o, done_o, cpu_stall_o = 0; dump_kind/index/data = 0.
- States: RUN, DUMP_REG, DUMP_MEM, DONE. cpu_stall_o = (state != RUN), decoded from the state register.
- RUN, per edge:
  - cycle_cnt += 1.
  - prev_pc <= pc_i.
  - stable_cnt: if pc_i == prev_pc, increment (saturating at HALT_STABLE); otherwise 0. The first edge after reset never counts as stable.
  - timeout = (cycle_cnt == END_COUNT-1). halt = (HALT_STABLE != 0) && (pc_i == prev_pc) && (stable_cnt == HALT_STABLE-1).
  - If timeout or halt: halt_cause <= {halt, timeout}; state <= DUMP_REG (DUMP_MEM if REG_CNT == 0; DONE if both counts are 0); idx <= 0.
  - Net effect: the CPU gets at most END_COUNT unstalled cycles.
- cycle_cnt_o and halt_cause_o freeze outside RUN.
- Dump states:
  - Read addresses are combinational: reg_raddr_o = idx[4:0] in DUMP_REG, else 0. mem_raddr_o = idx*4 in DUMP_MEM, else 0.
  - load = !dump_valid_o || dump_ready_i.
  - DUMP_REG, load && idx < REG_CNT: dump_data <= reg_rdata_i, kind <= 0, index <= idx, valid <= 1, idx += 1.
  - DUMP_REG, load && idx == REG_CNT: valid <= 0, idx <= 0, state <= DUMP_MEM (DONE if MEM_WORDS == 0). One bubble cycle between sections.
  - DUMP_MEM: same rules with mem_rdata_i and kind = 1; on completion, state <= DONE.
  - While dump_valid_o && !dump_ready_i: kind, index and data hold stable and idx does not advance.
  - A beat transfers on an edge with valid && ready.
- DONE: done_o = 1, valid = 0, stall stays 1. Leaves DONE only on reset.
- Register 0 is dumped as whatever the register file returns; no special-casing.

Test Plan:
- END_COUNT=20, HALT_STABLE=0, pc_i increments by 4 every cycle -> cpu_stall_o rises after exactly 20 unstalled edges; cycle_cnt_o=20; halt_cause_o=01.
- pc_i advances through 0x0..0x28, then holds 0x2c; HALT_STABLE=4 -> stall asserted once pc_i has equalled the previous value on 4 consecutive edges; halt_cause_o=10; cycle_cnt_o < END_COUNT.
- Both conditions true on the same edge (END_COUNT=10, PC held from cycle 5, HALT_STABLE=4) -> halt_cause_o=11.
- REG_CNT=4, MEM_WORDS=3, register file returns 10*addr, memory returns addr+1, ready tied 1 -> beats (0,0,0),(0,1,10),(0,2,20),(0,3,30), one bubble, then (1,0,1),(1,1,5),(1,2,9); done_o=1 after the last beat.
- Same setup, ready toggling 1-0-0-1 -> no beat lost or duplicated; payload stable while ready=0; same 7-beat sequence.
- rst_i pulled low mid DUMP_MEM -> next edge: RUN, valid=0, done=0, stall=0, counters 0. Also REG_CNT=0, MEM_WORDS=0 -> DONE directly after the run ends, with no beats.
